// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - write-back trace ring buffer with fill-stop / wrap-until-trigger capture and oldest-first drain
module wb_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 16,
  parameter int POST   = 4
) (
  input  logic                      ref_clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      mode,
  input  logic [DATA_W-1:0]         trig_pc,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [REG_W-1:0]          in_reg,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_pc,
  output logic [REG_W-1:0]          rd_reg,
  output logic [DATA_W-1:0]         rd_data,
  output logic [1:0]                state,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    stIdle    = 2'd0,
    stCapture = 2'd1,
    stPost    = 2'd2,
    stDone    = 2'd3
  } stateT;

  stateT             curState, nextState;
  logic [AW-1:0]     wrPtr, wrPtrNext;
  logic [AW-1:0]     rdPtr, rdPtrNext;
  logic [CW-1:0]     countNext;
  logic              overflowNext, triggeredNext;
  logic [AW-1:0]     postCnt, postCntNext;
  logic              modeQ, modeNext;
  logic [DATA_W-1:0] trigPcQ, trigPcNext;
  logic              memWe;
  logic              accept, hit, full, rdValid, pop;

  logic [DATA_W-1:0] pcMem   [DEPTH];
  logic [REG_W-1:0]  regMem  [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];

  // Event qualification and drain handshake; register-0 writes never count as events
  always_comb begin
    accept  = in_valid && (in_reg != '0) && ((curState == stCapture) || (curState == stPost));
    hit     = (in_pc == trigPcQ);
    full    = (count == CW'(DEPTH));
    rdValid = (curState == stDone) && (count != '0);
    pop     = rdValid && rd_ready;
  end

  // Next-state and pointer/count update; arm overrides any same-cycle event or pop
  always_comb begin
    nextState     = curState;
    wrPtrNext     = wrPtr;
    rdPtrNext     = rdPtr;
    countNext     = count;
    overflowNext  = overflow;
    triggeredNext = triggered;
    postCntNext   = postCnt;
    modeNext      = modeQ;
    trigPcNext    = trigPcQ;
    memWe         = 1'b0;
    if (arm) begin
      nextState     = stCapture;
      wrPtrNext     = '0;
      rdPtrNext     = '0;
      countNext     = '0;
      overflowNext  = 1'b0;
      triggeredNext = 1'b0;
      postCntNext   = '0;
      modeNext      = mode;
      trigPcNext    = trig_pc;
    end else begin
      case (curState)
        stCapture: begin
          if (accept) begin
            memWe     = 1'b1;
            wrPtrNext = wrPtr + 1'b1;
            if (!modeQ) begin
              countNext = count + 1'b1;
              if (hit) begin
                triggeredNext = 1'b1;
                nextState     = stDone;
              end else if (count == CW'(DEPTH - 1)) begin
                nextState = stDone;
              end
            end else begin
              // A full ring drops its oldest entry by advancing the read side
              if (full) begin
                rdPtrNext    = rdPtr + 1'b1;
                overflowNext = 1'b1;
              end else begin
                countNext = count + 1'b1;
              end
              if (hit) begin
                triggeredNext = 1'b1;
                if (POST == 0) begin
                  nextState = stDone;
                end else begin
                  nextState   = stPost;
                  postCntNext = AW'(POST);
                end
              end
            end
          end
        end
        stPost: begin
          if (accept) begin
            memWe       = 1'b1;
            wrPtrNext   = wrPtr + 1'b1;
            postCntNext = postCnt - 1'b1;
            if (full) begin
              rdPtrNext    = rdPtr + 1'b1;
              overflowNext = 1'b1;
            end else begin
              countNext = count + 1'b1;
            end
            if (postCnt == AW'(1)) begin
              nextState = stDone;
            end
          end
        end
        stDone: begin
          if (pop) begin
            rdPtrNext = rdPtr + 1'b1;
            countNext = count - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control state register with asynchronous clear
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      curState  <= stIdle;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      triggered <= 1'b0;
      postCnt   <= '0;
      modeQ     <= 1'b0;
      trigPcQ   <= '0;
    end else begin
      curState  <= nextState;
      wrPtr     <= wrPtrNext;
      rdPtr     <= rdPtrNext;
      count     <= countNext;
      overflow  <= overflowNext;
      triggered <= triggeredNext;
      postCnt   <= postCntNext;
      modeQ     <= modeNext;
      trigPcQ   <= trigPcNext;
    end
  end

  // Trace storage; contents are don't-care after reset so it carries no clear
  always_ff @(posedge ref_clk) begin
    if (memWe) begin
      pcMem[wrPtr]   <= in_pc;
      regMem[wrPtr]  <= in_reg;
      dataMem[wrPtr] <= in_data;
    end
  end

  // Read port shows the oldest entry combinationally, zeroed when nothing is presented
  always_comb begin
    rd_valid = rdValid;
    rd_pc    = rdValid ? pcMem[rdPtr]   : '0;
    rd_reg   = rdValid ? regMem[rdPtr]  : '0;
    rd_data  = rdValid ? dataMem[rdPtr] : '0;
    state    = curState;
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb/tb_wb_trace_buffer.sv - scoreboard bench for wb_trace_buffer
module tb_wb_trace_buffer;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int DEPTH = 4;

  logic          ref_clk = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] trig_pc = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_pc = '0;
  logic [RW-1:0] in_reg = '0;
  logic [DW-1:0] in_data = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_pc;
  logic [RW-1:0] rd_reg;
  logic [DW-1:0] rd_data;
  logic [1:0]    state;
  logic [2:0]    count;
  logic          overflow;
  logic          triggered;

  typedef struct {
    logic [DW-1:0] pc;
    logic [RW-1:0] rg;
    logic [DW-1:0] data;
  } entT;

  entT sb[$];
  int  vecs = 0;
  int  errs = 0;

  wb_trace_buffer #(.DATA_W(DW), .REG_W(RW), .DEPTH(DEPTH), .POST(1)) dut (
    .ref_clk(ref_clk), .reset(reset), .arm(arm), .mode(mode), .trig_pc(trig_pc),
    .in_valid(in_valid), .in_pc(in_pc), .in_reg(in_reg), .in_data(in_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_reg(rd_reg),
    .rd_data(rd_data), .state(state), .count(count), .overflow(overflow),
    .triggered(triggered)
  );

  always #5 ref_clk = ~ref_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic arm_capture(input logic m, input logic [DW-1:0] tpc);
    arm = 1'b1; mode = m; trig_pc = tpc;
    step();
    arm = 1'b0;
  endtask

  task automatic send_event(input logic [DW-1:0] pc, input logic [RW-1:0] rg, input logic [DW-1:0] d);
    in_valid = 1'b1; in_pc = pc; in_reg = rg; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [DW-1:0] pc, input logic [RW-1:0] rg, input logic [DW-1:0] d);
    entT e;
    e.pc = pc; e.rg = rg; e.data = d;
    sb.push_back(e);
  endtask

  task automatic check_status(input string name, input logic [1:0] st, input int cnt, input logic ov, input logic tr);
    vecs++;
    if (state !== st || count !== cnt[2:0] || overflow !== ov || triggered !== tr) begin
      errs++;
      $display("FAIL %s: state=%0d count=%0d ovf=%0b trig=%0b, want state=%0d count=%0d ovf=%0b trig=%0b",
               name, state, count, overflow, triggered, st, cnt, ov, tr);
    end
  endtask

  task automatic drain_all(input string name);
    int guard = 0;
    rd_ready = 1'b1;
    while (sb.size() > 0 && guard < 3 * DEPTH) begin
      vecs++;
      if (rd_valid !== 1'b1 || rd_pc !== sb[0].pc || rd_reg !== sb[0].rg || rd_data !== sb[0].data ||
          count !== sb.size()) begin
        errs++;
        $display("FAIL %s drain: v=%0b pc=%h reg=%0d data=%h count=%0d, want pc=%h reg=%0d data=%h count=%0d",
                 name, rd_valid, rd_pc, rd_reg, rd_data, count, sb[0].pc, sb[0].rg, sb[0].data, sb.size());
      end
      void'(sb.pop_front());
      step();
      guard++;
    end
    rd_ready = 1'b0;
    vecs++;
    if (sb.size() != 0 || rd_valid !== 1'b0 || count !== 3'd0 || rd_pc !== '0 || rd_reg !== '0 || rd_data !== '0) begin
      errs++;
      $display("FAIL %s empty: left=%0d v=%0b count=%0d pc=%h reg=%0d data=%h, want all 0",
               name, sb.size(), rd_valid, count, rd_pc, rd_reg, rd_data);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      arm = 1'b1; in_valid = 1'b1; in_reg = RW'(i + 1); in_pc = DW'(i * 4); rd_ready = 1'b1;
      step();
    end
    check_status("reset", 2'd0, 0, 1'b0, 1'b0);
    vecs++;
    if (rd_valid !== 1'b0 || rd_pc !== '0 || rd_reg !== '0 || rd_data !== '0) begin
      errs++;
      $display("FAIL reset rd: v=%0b pc=%h reg=%0d data=%h, want 0", rd_valid, rd_pc, rd_reg, rd_data);
    end
    arm = 1'b0; in_valid = 1'b0; rd_ready = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_fill_stop();
    arm_capture(1'b0, 32'hFFFF_FFFC);
    check_status("fill armed", 2'd1, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) push_exp(32'h100 + 32'(4 * i), RW'(i), 32'(16 * i));
      send_event(32'h100 + 32'(4 * i), RW'(i), 32'(16 * i));
      if (i == 3) check_status("fill 3", 2'd1, 3, 1'b0, 1'b0);
      if (i == 4) check_status("fill full", 2'd3, 4, 1'b0, 1'b0);
    end
    check_status("fill ignore", 2'd3, 4, 1'b0, 1'b0);
    drain_all("fill");
    check_status("fill after", 2'd3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reg0_filter();
    logic [RW-1:0] regs [4] = '{5'd0, 5'd3, 5'd0, 5'd7};
    arm_capture(1'b0, 32'h0000_0900);
    for (int i = 0; i < 4; i++) begin
      if (regs[i] != 0) push_exp(32'h500 + 32'(4 * i), regs[i], 32'hA0 + 32'(i));
      send_event(32'h500 + 32'(4 * i), regs[i], 32'hA0 + 32'(i));
    end
    check_status("reg0 count", 2'd1, 2, 1'b0, 1'b0);
    push_exp(32'h900, 5'd9, 32'hBEEF);
    send_event(32'h900, 5'd9, 32'hBEEF);
    check_status("reg0 trig", 2'd3, 3, 1'b0, 1'b1);
    drain_all("reg0");
  endtask

  task automatic test_wrap_trigger();
    logic [DW-1:0] d;
    arm_capture(1'b1, 32'h20);
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      push_exp(32'(4 * i), RW'(i + 1), d);
      if (sb.size() > DEPTH) void'(sb.pop_front());
      send_event(32'(4 * i), RW'(i + 1), d);
      if (i == 3) check_status("wrap full", 2'd1, 4, 1'b0, 1'b0);
      if (i == 8) check_status("wrap post", 2'd2, 4, 1'b1, 1'b1);
    end
    check_status("wrap done", 2'd3, 4, 1'b1, 1'b1);
    drain_all("wrap");
  endtask

  task automatic test_arm_priority();
    arm_capture(1'b0, 32'h200);
    push_exp(32'h300, 5'd1, 32'h11);
    send_event(32'h300, 5'd1, 32'h11);
    push_exp(32'h200, 5'd2, 32'h22);
    send_event(32'h200, 5'd2, 32'h22);
    check_status("prio done", 2'd3, 2, 1'b0, 1'b1);
    arm = 1'b1; mode = 1'b0; trig_pc = 32'h400;
    in_valid = 1'b1; in_pc = 32'h400; in_reg = 5'd5; in_data = 32'h55; rd_ready = 1'b1;
    step();
    arm = 1'b0; in_valid = 1'b0; rd_ready = 1'b0;
    sb.delete();
    check_status("prio arm", 2'd1, 0, 1'b0, 1'b0);
    vecs++;
    if (rd_valid !== 1'b0) begin
      errs++;
      $display("FAIL prio rd_valid: got %0b want 0", rd_valid);
    end
    push_exp(32'h400, 5'd6, 32'h66);
    send_event(32'h400, 5'd6, 32'h66);
    check_status("prio trig", 2'd3, 1, 1'b0, 1'b1);
    drain_all("prio");
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] hpc, hdata;
    logic [RW-1:0] hreg;
    arm_capture(1'b0, 32'hFFFF_FFFC);
    for (int i = 0; i < DEPTH; i++) begin
      push_exp(32'h700 + 32'(4 * i), RW'(20 + i), 32'hC00 + 32'(i));
      send_event(32'h700 + 32'(4 * i), RW'(20 + i), 32'hC00 + 32'(i));
    end
    check_status("bp done", 2'd3, 4, 1'b0, 1'b0);
    rd_ready = 1'b1;
    step();
    void'(sb.pop_front());
    rd_ready = 1'b0;
    hpc = rd_pc; hreg = rd_reg; hdata = rd_data;
    step();
    vecs++;
    if (rd_pc !== hpc || rd_reg !== hreg || rd_data !== hdata || rd_pc !== sb[0].pc || rd_data !== sb[0].data) begin
      errs++;
      $display("FAIL bp hold: pc=%h reg=%0d data=%h, want pc=%h data=%h", rd_pc, rd_reg, rd_data, sb[0].pc, sb[0].data);
    end
    rd_ready = 1'b1;
    step();
    void'(sb.pop_front());
    rd_ready = 1'b0;
    check_status("bp two pops", 2'd3, 2, 1'b0, 1'b0);
    vecs++;
    if (rd_valid !== 1'b1 || rd_pc !== sb[0].pc || rd_reg !== sb[0].rg) begin
      errs++;
      $display("FAIL bp next: v=%0b pc=%h reg=%0d, want pc=%h reg=%0d", rd_valid, rd_pc, rd_reg, sb[0].pc, sb[0].rg);
    end
    #2 reset = 1'b0;
    #1;
    check_status("bp async reset", 2'd0, 0, 1'b0, 1'b0);
    vecs++;
    if (rd_valid !== 1'b0 || rd_pc !== '0) begin
      errs++;
      $display("FAIL bp reset rd: v=%0b pc=%h, want 0", rd_valid, rd_pc);
    end
    sb.delete();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_fill_stop();
    test_reg0_filter();
    test_wrap_trigger();
    test_arm_priority();
    test_back_pressure();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Parametrised write-back trace capture block for the five-stage pipelined 32-bit processor. It records register-file write-back events (PC, destination register, result) into an on-chip ring buffer of configurable depth. Capture is armed, runs in fill-stop or wrap-until-trigger mode, and the buffer is drained oldest-first over a valid/ready port. It sits beside the W stage and replaces waveform-only observation of the pipeline with a synthesizable, readable trace.

## Interface
Parameters:
- DATA_W, 32, width of captured PC and result
- REG_W, 5, width of destination register index
- DEPTH, 16, number of trace entries; power of two, at least 2
- POST, 4, entries captured after a trigger match in wrap mode; 0 to DEPTH-1

Ports:
- ref_clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle start pulse; clears the buffer and begins capture
- mode  in  1  sampled when arm=1; 0 = fill-stop, 1 = wrap-until-trigger
- trig_pc  in  DATA_W  trigger PC; sampled when arm=1
- in_valid  in  1  write-back event this cycle (RegWriteW)
- in_pc  in  DATA_W  PC of the writing instruction
- in_reg  in  REG_W  destination register (WriteRegW)
- in_data  in  DATA_W  written value (ResultW)
- rd_ready  in  1  consumer accepts the current read entry
- rd_valid  out  1  a read entry is presented
- rd_pc  out  DATA_W  PC of the presented entry; 0 when rd_valid=0
- rd_reg  out  REG_W  register of the presented entry; 0 when rd_valid=0
- rd_data  out  DATA_W  value of the presented entry; 0 when rd_valid=0
- state  out  2  0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
- count  out  clog2(DEPTH)+1  number of valid entries held
- overflow  out  1  at least one entry was overwritten during this capture (wrap mode)
- triggered  out  1  a trigger match was captured during this capture

## Operation
- Reset (asynchronous, while reset=0): state=IDLE, count=0, write and read pointers=0, overflow=0, triggered=0, POST counter=0, rd_valid=0. Storage contents are don't-care.
- Accepted event: in_valid=1 and in_reg!=0, in CAPTURE or POST. Writes to register 0 are discarded and change nothing.
- arm=1 in any state: pointers, count, overflow and triggered are cleared; mode and trig_pc are latched; next state is CAPTURE. arm has priority over a same-cycle event (the event is dropped) and over a same-cycle pop.
- CAPTURE, mode 0: each accepted event writes at wr_ptr, wr_ptr+1, count+1.
  - If the event matches trig_pc: triggered=1 and the next state is DONE.
  - Otherwise, if count reaches DEPTH: the next state is DONE.
- CAPTURE, mode 1: each accepted event writes at wr_ptr and wr_ptr+1.
  - If count<DEPTH: count+1.
  - If count=DEPTH: the oldest entry is overwritten, rd_ptr+1, count is unchanged, overflow=1.
  - On an event matching trig_pc: triggered=1. If POST=0 the next state is DONE; otherwise the next state is POST with the POST counter loaded to POST.
- POST: accepted events are written with the same wrap rules. The POST counter decrements per event; the event that takes it to 0 is stored and the next state is DONE. Further trig_pc matches are ignored.
- DONE: rd_valid=(count!=0). rd_* show the entry at rd_ptr (oldest). A pop (rd_valid and rd_ready) advances rd_ptr and decrements count. At count=0, the block stays in DONE until arm. Events are ignored.
- IDLE, CAPTURE, POST: rd_valid=0 and rd_ready is ignored.
- Pointers are clog2(DEPTH) bits and wrap naturally modulo DEPTH.

## Timing
- A captured event is visible in count one cycle after its sampling edge.
- A state change is visible one cycle after the causing edge. DONE is entered on the edge that stores the last entry.
- rd_pc, rd_reg and rd_data are combinational from storage at rd_ptr. The next entry is presented in the cycle after a pop. With rd_ready held at 1, the drain rate is 1 entry per cycle.
- No bubble between the last capture and the first rd_valid: rd_valid is 1 in the first DONE cycle.
- Reset asserted mid-capture or mid-drain takes effect immediately: all outputs go to their reset values asynchronously.

## Test plan
- Reset: hold reset=0 with activity on the inputs -> state=0, count=0, rd_valid=0, overflow=0, triggered=0, rd_*=0.
- Fill-stop (DEPTH=4, mode 0, no match): 5 events with reg 1..5 and data 0x10..0x50 -> DONE after the 4th; drain returns regs 1,2,3,4 in order; count goes 4→0; rd_valid drops once count=0.
- Register-0 filter: events with reg 0, 3, 0, 7 in CAPTURE -> count=2; drain returns 3 then 7.
- Wrap plus trigger (DEPTH=4, POST=1, mode 1, trig_pc=0x20): PCs 0x00,0x04,...,0x20,0x24 (10 events) -> overflow=1, triggered=1, state=3; drain gives PCs 0x18,0x1C,0x20,0x24.
- Arm priority: arm coincides with in_valid and with a pop in DONE -> state=1, count=0, the event is not stored; a trigger in mode 0 stores the matching entry, then DONE with triggered=1.
- Back-pressure: in DONE, toggle rd_ready 1,0,1 -> only 2 pops; rd_* are stable while rd_ready=0; reset asserted mid-drain clears count immediately.
